// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a small TX FIFO that a
// registered serial shifter drains as back-to-back frames on tx.
module uart_tx_port #(
  parameter int              BITS         = 32,
  parameter logic [BITS-1:0] BASE         = 32'hF0000030,
  parameter logic [BITS-1:0] CTRL_BASE    = 32'hF0000130,
  parameter int              CLKS_PER_BIT = 217,
  parameter int              FIFO_AW      = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic            re,
  input  logic [BITS-1:0] memAddr,
  input  logic [BITS-1:0] dataBusIn,
  output logic [BITS-1:0] dataBusOut,
  output logic            tx
);

  localparam int                 DEPTH      = 1 << FIFO_AW;
  localparam int                 BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_e;

  logic [7:0]         fifoMem [DEPTH];
  logic [FIFO_AW-1:0] wrPtr, rdPtr;
  logic [FIFO_AW:0]   fifoCount;
  logic               overflow;
  logic               fifoFull, fifoEmpty, push, pop;
  logic               dataWrite, ctrlWrite, ctrlRead, busy;

  txState_e           state, nextState;
  logic [BAUD_W-1:0]  baudCnt, nextBaud;
  logic [2:0]         bitIdx, nextBitIdx;
  logic [7:0]         shiftReg, nextShift;
  logic               nextTx, bitEnd;
  logic [BITS-1:0]    status;
  logic               unusedBits;

  assign dataWrite = we && (memAddr == BASE);
  assign ctrlWrite = we && (memAddr == CTRL_BASE);
  assign ctrlRead  = re && !we && (memAddr == CTRL_BASE);
  assign fifoFull  = (fifoCount == FULL_COUNT);
  assign fifoEmpty = (fifoCount == '0);
  // A full FIFO refuses the store even if the shifter pops in the same cycle.
  assign push      = dataWrite && !fifoFull;
  assign busy      = (state != IDLE) || !fifoEmpty;
  assign bitEnd    = (baudCnt == BAUD_LAST);
  assign unusedBits = ^dataBusIn[BITS-1:8];

  // NOTE: storage has no reset; an entry is only read after push has counted it in.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= dataBusIn[7:0];
  end

  // NOTE: every register uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: ;
      endcase
      if (dataWrite && fifoFull)           overflow <= 1'b1;
      else if (ctrlWrite && !dataBusIn[2]) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= nextState;
      baudCnt  <= nextBaud;
      bitIdx   <= nextBitIdx;
      shiftReg <= nextShift;
      tx       <= nextTx;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned.
  always_comb begin
    nextState  = state;
    nextBitIdx = bitIdx;
    pop        = 1'b0;
    nextBaud   = (state == IDLE || bitEnd) ? '0 : baudCnt + 1'b1;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          nextState = START;
          pop       = 1'b1;
        end
      end
      START: begin
        if (bitEnd) begin
          nextState  = DATA;
          nextBitIdx = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitIdx == 3'd7) nextState  = STOP;
          else                nextBitIdx = bitIdx + 1'b1;
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (!fifoEmpty) begin
            nextState = START;
            pop       = 1'b1;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // tx is registered from the next state so the start bit appears on the pop edge.
  always_comb begin
    nextShift = shiftReg;
    if (pop)                         nextShift = fifoMem[rdPtr];
    else if (state == DATA && bitEnd) nextShift = shiftReg >> 1;
    case (nextState)
      START:   nextTx = 1'b0;
      DATA:    nextTx = nextShift[0];
      default: nextTx = 1'b1;
    endcase
  end

  always_comb begin
    status                 = '0;
    status[8+FIFO_AW:8]    = fifoCount;
    status[2]              = overflow;
    status[1]              = busy;
    status[0]              = !fifoFull;
  end

  assign dataBusOut = ctrlRead ? status : '0;

endmodule
